// File: rtl/wave_capture_ctrl.sv
// Capture sequencer for the double-buffered waveform RAM: zero-crossing trigger, one frame per buffer, swap on display idle.
// Optional build macro TRIGGER_TIMEOUT_EN forces a capture after TIMEOUT strobes without a trigger.
//
// state     | meaning
// ST_ARMED  | waiting for a negative-to-non-negative crossing (or forced trigger)
// ST_ACTIVE | storing one frame into the half the display is not reading
// ST_WAIT   | frame complete; flip read_index on the first idle cycle
module wave_capture_ctrl #(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 8,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_sample_ready,
    input  logic [SAMPLE_W-1:0] new_sample_in,
    input  logic                wave_display_idle,
    output logic [ADDR_W:0]     write_address,
    output logic                write_enable,
    output logic [7:0]          write_sample,
    output logic                read_index
);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_prev_neg;
    logic                r_read_index;
    logic                r_we;
    logic [ADDR_W:0]     r_addr;
    logic [7:0]          r_sample;

    logic                w_sign;
    logic [7:0]          w_conv;
    logic                w_force;
    logic                w_trigger;

    assign w_sign = new_sample_in[SAMPLE_W-1];
    // Top byte with the sign bit flipped gives offset binary (0x80 = zero).
    assign w_conv = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]};

`ifdef TRIGGER_TIMEOUT_EN
    localparam int QW = $clog2(TIMEOUT + 1);
    logic [QW-1:0] r_quiet;

    assign w_force = (r_quiet == QW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_quiet <= '0;
        end else if (r_state != ST_ARMED || w_trigger) begin
            r_quiet <= '0;
        end else if (new_sample_ready) begin
            r_quiet <= r_quiet + 1'b1;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    assign w_trigger = new_sample_ready & ((r_prev_neg & ~w_sign) | w_force);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_ARMED;
            r_cnt        <= '0;
            r_prev_neg   <= 1'b0;
            r_read_index <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_sample     <= '0;
        end else begin
            r_we <= 1'b0;
            if (new_sample_ready) begin
                r_prev_neg <= w_sign;
            end
            case (r_state)
                ST_ARMED: begin
                    if (w_trigger) begin
                        r_we     <= 1'b1;
                        r_addr   <= {~r_read_index, {ADDR_W{1'b0}}};
                        r_sample <= w_conv;
                        r_cnt    <= ADDR_W'(1);
                        r_state  <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (new_sample_ready) begin
                        r_we     <= 1'b1;
                        r_addr   <= {~r_read_index, r_cnt};
                        r_sample <= w_conv;
                        r_cnt    <= r_cnt + 1'b1;
                        if (&r_cnt) begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wave_display_idle) begin
                        r_read_index <= ~r_read_index;
                        r_state      <= ST_ARMED;
                    end
                end
                default: begin
                    r_state <= ST_ARMED;
                end
            endcase
        end
    end

    assign write_address = r_addr;
    assign write_enable  = r_we;
    assign write_sample  = r_sample;
    assign read_index    = r_read_index;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Self-checking bench for wave_capture_ctrl against a frame-level behavioural model.
// Build with +define+TRIGGER_TIMEOUT_EN to exercise the forced-trigger variant.
module tb_wave_capture_ctrl;
    localparam int TIMEOUT = 1024;
    localparam int FRAME   = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rdy = 1'b0;
    logic [15:0] smp = '0;
    logic        idle = 1'b0;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    int checks = 0;
    int errors = 0;

    // model state: samples still owed to the current frame, waiting-for-swap flag
    bit         m_we;
    logic [8:0] m_addr;
    logic [7:0] m_smp;
    bit         m_ri;
    int         m_left;
    bit         m_wait;
    bit         m_prevneg;
    int         m_quiet;

    wave_capture_ctrl #(.SAMPLE_W(16), .ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (rdy),
        .new_sample_in     (smp),
        .wave_display_idle (idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_offset(input logic [15:0] s);
        int v;
        v = int'($signed(s)) + 32768;
        return 8'(v / 256);
    endfunction

    task automatic m_reset();
        m_we = 0; m_addr = '0; m_smp = '0; m_ri = 0;
        m_left = 0; m_wait = 0; m_prevneg = 0; m_quiet = 0;
    endtask

    task automatic m_write(input int idx, input logic [15:0] s);
        m_we   = 1;
        m_addr = {~m_ri, 8'(idx)};
        m_smp  = to_offset(s);
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic step(input bit r, input logic [15:0] s, input bit id);
        bit was_wait;
        bit trig;
        rdy = r; smp = s; idle = id;
        @(posedge clk);
        was_wait = m_wait;
        m_we = 0;
        if (r) begin
            if (m_left > 0) begin
                m_write(FRAME - m_left, s);
                m_left--;
                if (m_left == 0) m_wait = 1;
            end else if (!was_wait) begin
                trig = m_prevneg && !s[15];
`ifdef TRIGGER_TIMEOUT_EN
                if (m_quiet == TIMEOUT - 1) trig = 1;
`endif
                if (trig) begin
                    m_write(0, s);
                    m_left  = FRAME - 1;
                    m_quiet = 0;
                end else begin
                    m_quiet++;
                end
            end
            m_prevneg = s[15];
        end
        if (was_wait && id) begin
            m_ri   = !m_ri;
            m_wait = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rdy = 0; idle = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        m_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m_reset();
        #1;
        checks++;
        if ({write_enable, write_address, write_sample, read_index} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state got we=%0b a=%h d=%h ri=%0b exp all zero",
                     write_enable, write_address, write_sample, read_index);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_first_trigger();
        logic [15:0] seq [4];
        bit          rv [4];
        seq = '{16'h0100, 16'h7777, 16'hFF00, 16'h0005};
        rv  = '{1, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            step(rv[i], seq[i], 0);
            checks++;
            if ({write_enable, write_address, write_sample, read_index} !== {m_we, m_addr, m_smp, m_ri}) begin
                errors++;
                $display("FAIL first_trigger[%0d] got we=%0b a=%h d=%h ri=%0b exp we=%0b a=%h d=%h ri=%0b", i,
                         write_enable, write_address, write_sample, read_index, m_we, m_addr, m_smp, m_ri);
            end
        end
        checks++;
        if ({write_enable, write_address, write_sample, read_index} !== {1'b1, 9'h100, 8'h80, 1'b0}) begin
            errors++;
            $display("FAIL first_write got we=%0b a=%h d=%h ri=%0b exp we=1 a=100 d=80 ri=0",
                     write_enable, write_address, write_sample, read_index);
        end
    endtask

    task automatic test_ramp();
        int pulses = 0;
        for (int i = 1; i < FRAME; i++) begin
            step(1, 16'(((i - 1) % 64) * 16'h0200), 0);
            if (write_enable) pulses++;
            checks++;
            if ({write_enable, write_address, write_sample, read_index} !== {m_we, m_addr, m_smp, m_ri}) begin
                errors++;
                $display("FAIL ramp[%0d] got we=%0b a=%h d=%h ri=%0b exp we=%0b a=%h d=%h ri=%0b", i,
                         write_enable, write_address, write_sample, read_index, m_we, m_addr, m_smp, m_ri);
            end
            if (i % 3 == 0) step(0, 16'h0, 0);
        end
        checks++;
        if (pulses != FRAME - 1) begin
            errors++;
            $display("FAIL ramp_pulses got %0d exp %0d", pulses, FRAME - 1);
        end
        for (int i = 0; i < 6; i++) begin
            step(1, (i % 2) ? 16'h0300 : 16'hC000, 0);
            checks++;
            if (write_enable !== 1'b0 || read_index !== 1'b0) begin
                errors++;
                $display("FAIL wait_no_write[%0d] got we=%0b ri=%0b exp we=0 ri=0", i, write_enable, read_index);
            end
        end
    endtask

    task automatic test_swap();
        int pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 16'h0, 1);
            checks++;
            if (read_index !== 1'b1 || read_index !== m_ri) begin
                errors++;
                $display("FAIL swap[%0d] got ri=%0b exp ri=1", i, read_index);
            end
        end
        step(1, 16'hF000, 0);
        step(1, 16'h0100, 0);
        checks++;
        if ({write_enable, write_address} !== {1'b1, 9'h000}) begin
            errors++;
            $display("FAIL swap_first_addr got we=%0b a=%h exp we=1 a=000", write_enable, write_address);
        end
        pulses = 1;
        for (int i = 1; i < FRAME + 4; i++) begin
            step(1, 16'($urandom_range(0, 65535)), 0);
            if (write_enable) pulses++;
            checks++;
            if ({write_enable, write_address, write_sample, read_index} !== {m_we, m_addr, m_smp, m_ri}) begin
                errors++;
                $display("FAIL swap_frame[%0d] got we=%0b a=%h d=%h ri=%0b exp we=%0b a=%h d=%h ri=%0b", i,
                         write_enable, write_address, write_sample, read_index, m_we, m_addr, m_smp, m_ri);
            end
        end
        checks++;
        if (pulses != FRAME) begin
            errors++;
            $display("FAIL swap_pulses got %0d exp %0d", pulses, FRAME);
        end
    endtask

    task automatic test_reset_mid();
        step(0, 16'h0, 1);
        step(1, 16'h8000, 0);
        for (int i = 0; i < FRAME; i++) step(1, 16'h0040, 0);
        step(0, 16'h0, 1);
        checks++;
        if (read_index !== 1'b1 || m_ri !== 1'b1) begin
            errors++;
            $display("FAIL premid_ri got ri=%0b exp ri=1", read_index);
        end
        step(1, 16'hFFFF, 0);
        for (int i = 0; i < 101; i++) step(1, 16'($urandom_range(0, 65535)), 0);
        #2;
        reset = 1'b0;
        #1;
        m_reset();
        checks++;
        if ({write_enable, write_address, write_sample, read_index} !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid got we=%0b a=%h d=%h ri=%0b exp all zero",
                     write_enable, write_address, write_sample, read_index);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1, 16'h1234, 0);
            checks++;
            if (write_enable !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_trig[%0d] got we=%0b exp 0", i, write_enable);
            end
        end
        step(1, 16'hA000, 0);
        step(1, 16'h0000, 0);
        checks++;
        if ({write_enable, write_address, write_sample} !== {1'b1, 9'h100, 8'h80}) begin
            errors++;
            $display("FAIL reset_restart got we=%0b a=%h d=%h exp we=1 a=100 d=80",
                     write_enable, write_address, write_sample);
        end
    endtask

    task automatic test_dc();
        int writes = 0;
        int first = -1;
        do_reset();
        for (int i = 1; i <= 2000; i++) begin
            step(1, 16'h1000, 0);
            if (write_enable) begin
                writes++;
                if (first < 0) first = i;
            end
            checks++;
            if ({write_enable, write_address, write_sample, read_index} !== {m_we, m_addr, m_smp, m_ri}) begin
                errors++;
                $display("FAIL dc[%0d] got we=%0b a=%h d=%h ri=%0b exp we=%0b a=%h d=%h ri=%0b", i,
                         write_enable, write_address, write_sample, read_index, m_we, m_addr, m_smp, m_ri);
            end
            if (i == TIMEOUT && write_enable) begin
                checks++;
                if (write_sample !== 8'h90) begin
                    errors++;
                    $display("FAIL dc_sample got %h exp 90", write_sample);
                end
            end
        end
`ifdef TRIGGER_TIMEOUT_EN
        checks++;
        if (writes != FRAME || first != TIMEOUT) begin
            errors++;
            $display("FAIL dc_timeout got writes=%0d first=%0d exp writes=%0d first=%0d", writes, first, FRAME, TIMEOUT);
        end
`else
        checks++;
        if (writes != 0 || read_index !== 1'b0) begin
            errors++;
            $display("FAIL dc_idle got writes=%0d ri=%0b exp writes=0 ri=0", writes, read_index);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int run = 0;
        int best = 0;
        do_reset();
        step(1, 16'hC123, 0);
        step(1, 16'h0001, 0);
        for (int i = 0; i < FRAME + 3; i++) begin
            if (write_enable) begin
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
            checks++;
            if ({write_enable, write_address, write_sample, read_index} !== {m_we, m_addr, m_smp, m_ri}) begin
                errors++;
                $display("FAIL b2b[%0d] got we=%0b a=%h d=%h ri=%0b exp we=%0b a=%h d=%h ri=%0b", i,
                         write_enable, write_address, write_sample, read_index, m_we, m_addr, m_smp, m_ri);
            end
            step(1, 16'($urandom_range(0, 65535)), 0);
        end
        checks++;
        if (best != FRAME) begin
            errors++;
            $display("FAIL b2b_run got %0d exp %0d", best, FRAME);
        end
    endtask

    task automatic test_random();
        logic [15:0] s;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            s = 16'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) s = -s;
            step($urandom_range(0, 1) == 1, s, $urandom_range(0, 9) == 0);
            checks++;
            if ({write_enable, write_address, write_sample, read_index} !== {m_we, m_addr, m_smp, m_ri}) begin
                errors++;
                $display("FAIL random[%0d] got we=%0b a=%h d=%h ri=%0b exp we=%0b a=%h d=%h ri=%0b", i,
                         write_enable, write_address, write_sample, read_index, m_we, m_addr, m_smp, m_ri);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_trigger();
        test_ramp();
        test_swap();
        test_reset_mid();
        test_dc();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_capture_ctrl.md
Name: wave_capture_ctrl

Overview:
Sequences the double-buffered 512-entry sample RAM that feeds the waveform display. It triggers on a positive-going zero crossing of the audio stream and writes one 256-sample frame into the half of the RAM the display is not reading. When the display reports it is idle, it flips read_index so the display swaps halves. It sits between the codec sample stream and the sample RAM, and drives the display's read_index input.

Parameters:
SAMPLE_W, 16, width of the signed input sample (two's complement).
ADDR_W, 8, address bits per RAM half; frame length = 2**ADDR_W = 256 samples.
TIMEOUT, 1024, accepted samples without a trigger before a forced capture (used only with TRIGGER_TIMEOUT_EN).

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid this cycle.
new_sample_in  input  SAMPLE_W  signed audio sample.
wave_display_idle  input  1  high while the display is outside its active region, so a buffer swap is safe.
write_address  output  ADDR_W+1  RAM write address = {~read_index, frame counter}.
write_enable  output  1  RAM write strobe, one cycle per stored sample.
write_sample  output  8  unsigned sample written to RAM.
read_index  output  1  selects the RAM half the display reads.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=ARMED; frame counter=0; prev_negative=0.
  - read_index=0, write_enable=0, write_address=0, write_sample=0.
  - Reset asserted mid-frame discards the partial frame. read_index returns to 0.
- Sample conversion: write_sample = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]}. This is the top byte of the sample converted to offset binary, so -32768 maps to 0x00, 0 to 0x80, and +32767 to 0xFF.
- prev_negative updates to new_sample_in[SAMPLE_W-1] on every accepted strobe, in all states.
- ARMED:
  - Trigger when a strobe arrives with prev_negative=1 and the current sample's sign bit is 0 (sample >= 0).
  - On trigger, the triggering sample is stored at frame index 0 and state becomes ACTIVE.
  - Non-trigger strobes are not written.
- ACTIVE:
  - Each strobe stores one sample at the next index; the counter increments by 1.
  - After the sample at index 2**ADDR_W-1 is stored, the counter wraps to 0 and state becomes WAIT.
- WAIT:
  - Strobes are ignored for writes; prev_negative still updates.
  - On the first cycle with wave_display_idle=1: read_index toggles, state becomes ARMED.
  - Exactly one toggle happens per WAIT entry, even if idle stays high.
- Write timing:
  - write_enable, write_address and write_sample are registered and update the cycle after the accepted strobe.
  - write_enable is high for exactly one cycle per stored sample.
  - write_address and write_sample hold their last values when write_enable=0.
- Write target: the write half is always ~read_index. The display's half is never written.
- Last sample and idle in the same cycle: the last write issues; WAIT is entered the next cycle. The earliest toggle is therefore one cycle after the last write_enable pulse.
- Consecutive strobes: back-to-back strobes (every cycle) are fully supported; no sample is dropped in ACTIVE.

Optional Feature:
TRIGGER_TIMEOUT_EN:
- Defined: an ARMED-state counter counts accepted strobes without a trigger. When it reaches TIMEOUT, the current strobe is a forced trigger (the frame starts at that sample). The counter clears on any trigger, on leaving ARMED, and on reset.
- Undefined: no timeout counter exists. ARMED waits indefinitely; a DC or silent input never captures and read_index never toggles.

Test Plan:
- Reset then release; strobes of samples 0x0100 then -0x0100 then 0x0005 -> first write_enable the cycle after the 0x0005 strobe, write_address=0x100, write_sample=0x80; read_index=0.
- Trigger, then 255 further strobes of ramp 0x0000..0x7E00 step 0x0200 with wave_display_idle=0 -> 256 write pulses at addresses 0x100..0x1FF; data 0x80..0xFE; then no writes, read_index still 0.
- Continue from the previous test, raise wave_display_idle for 3 cycles -> read_index=1 after the first cycle, no further toggle; the next frame writes addresses 0x000..0x0FF.
- Assert reset at frame index 100 -> outputs 0 and read_index=0 immediately (asynchronously); the next capture restarts at index 0 after a fresh negative-to-non-negative crossing.
- Constant sample 0x1000 for 2000 strobes -> without the macro, zero writes; with TRIGGER_TIMEOUT_EN and TIMEOUT=1024, writes start at the 1024th accepted strobe with write_sample=0x90.
- Strobes on every cycle with a crossing at the first sample -> 256 consecutive write_enable cycles, no gaps, no dropped indices.
